mc_core: RTL and testbench

Parametrised multicycle execution core, the next generation of the team's register-file / ALU / program-counter / control microprocessor. It accepts 32-bit instructions over a valid/ready handshake and runs each through a FETCH/READ/EXEC/WB state machine. MULT is an iterative shift-add multiplier, and conditional branches use a signed offset. Register count and data width are parameters, and an illegal-opcode indication is provided.

---
 rtl/mc_core.sv | 194 +++++++++++++++++++
 tb/tb_mc_core.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_core.sv
// mc_core: multicycle register-file / ALU / PC core with an iterative shift-add
// multiplier, signed-offset branch and an illegal-opcode indication.
module mc_core #(
   parameter int DATA_W  = 32,
   parameter int REG_CNT = 32,
   parameter int PC_W    = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [31:0]                ir,
   input  logic                       ir_valid,
   output logic                       ir_ready,
   output logic [PC_W-1:0]            pc,
   output logic                       flag_z,
   output logic                       flag_c,
   output logic                       flag_n,
   output logic                       done,
   output logic                       illegal,
   output logic                       busy,
   input  logic [$clog2(REG_CNT)-1:0] dbg_addr,
   output logic [DATA_W-1:0]          dbg_data
);

   localparam int AW = $clog2(REG_CNT);
   localparam int SW = $clog2(DATA_W);
   localparam int CW = SW + 1;

   typedef enum logic [1:0] {FETCH, READ, EXEC, WB} state_e;

   typedef enum logic [7:0] {
      OP_SUB  = 8'h0A,
      OP_BZ   = 8'h14,
      OP_MULT = 8'h1A,
      OP_RRS  = 8'h21,
      OP_NAND = 8'h22,
      OP_OR   = 8'h23
   } op_e;

   state_e              state;
   logic [7:0]          op_q;
   logic [AW-1:0]       rd_q;
   logic [AW-1:0]       ra_q;
   logic [AW-1:0]       rb_q;
   logic [8:0]          imm_q;
   logic [DATA_W-1:0]   a_q;
   logic [DATA_W-1:0]   b_q;
   logic [DATA_W-1:0]   res_q;
   logic                c_q;
   logic [2*DATA_W-1:0] prod_q;
   logic [CW-1:0]       mcnt;
   logic [DATA_W-1:0]   regs [REG_CNT];

   logic [DATA_W:0]     diff;
   logic [DATA_W:0]     a_ext;
   logic [DATA_W:0]     msum;
   logic [SW-1:0]       sh;
   logic [DATA_W-1:0]   alu_res;
   logic                alu_c;
   logic                legal;
   logic [AW-1:0]       rd_nxt;
   logic [PC_W-1:0]     imm_sext;
   logic                unused_ir;

   assign ir_ready  = (state == FETCH) && !reset;
   assign dbg_data  = regs[dbg_addr];
   assign rd_nxt    = rd_q + AW'(1);
   assign imm_sext  = {{(PC_W-9){imm_q[8]}}, imm_q};
   assign unused_ir = ^ir;

   // One shift-add step: conditionally add the multiplicand into the upper
   // half, then shift the whole product/multiplier register right by one.
   assign msum = {1'b0, prod_q[2*DATA_W-1:DATA_W]} + {1'b0, a_q & {DATA_W{prod_q[0]}}};

   always_comb begin
      diff    = {1'b0, a_q} - {1'b0, b_q};
      a_ext   = {a_q, 1'b0};
      sh      = b_q[SW-1:0];
      alu_res = '0;
      alu_c   = 1'b0;
      case (op_q)
         OP_SUB: begin
            alu_res = diff[DATA_W-1:0];
            alu_c   = diff[DATA_W];
         end
         OP_RRS: begin
            alu_res = $signed(a_q) >>> sh;
            // a_ext[sh] is ra[sh-1], and 0 when sh == 0
            alu_c   = a_ext[{1'b0, sh}];
         end
         OP_NAND: alu_res = ~(a_q & b_q);
         OP_OR:   alu_res = a_q | b_q;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      legal = 1'b0;
      case (op_q)
         OP_SUB, OP_BZ, OP_MULT, OP_RRS, OP_NAND, OP_OR: legal = 1'b1;
         default: legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= FETCH;
         pc      <= '0;
         flag_z  <= 1'b0;
         flag_c  <= 1'b0;
         flag_n  <= 1'b0;
         done    <= 1'b0;
         illegal <= 1'b0;
         busy    <= 1'b0;
         op_q    <= '0;
         rd_q    <= '0;
         ra_q    <= '0;
         rb_q    <= '0;
         imm_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         c_q     <= 1'b0;
         prod_q  <= '0;
         mcnt    <= '0;
         for (int unsigned i = 0; i < REG_CNT; i++) begin
            regs[i] <= DATA_W'(i);
         end
      end else begin
         done    <= 1'b0;
         illegal <= 1'b0;
         case (state)
            FETCH: begin
               if (ir_valid) begin
                  op_q  <= ir[31:24];
                  rd_q  <= ir[18 +: AW];
                  ra_q  <= ir[13 +: AW];
                  rb_q  <= ir[8 +: AW];
                  imm_q <= ir[8:0];
                  state <= READ;
                  busy  <= 1'b1;
               end
            end
            READ: begin
               a_q    <= regs[ra_q];
               b_q    <= regs[rb_q];
               prod_q <= {{DATA_W{1'b0}}, regs[rb_q]};
               mcnt   <= '0;
               state  <= EXEC;
            end
            EXEC: begin
               if (op_q == OP_MULT) begin
                  prod_q <= {msum, prod_q[DATA_W-1:1]};
                  mcnt   <= mcnt + 1'b1;
                  if (mcnt == CW'(DATA_W - 1)) begin
                     state <= WB;
                     done  <= 1'b1;
                  end
               end else begin
                  res_q   <= alu_res;
                  c_q     <= alu_c;
                  state   <= WB;
                  done    <= 1'b1;
                  illegal <= !legal;
               end
            end
            WB: begin
               state <= FETCH;
               busy  <= 1'b0;
               case (op_q)
                  OP_MULT: begin
                     regs[rd_q]   <= prod_q[2*DATA_W-1:DATA_W];
                     regs[rd_nxt] <= prod_q[DATA_W-1:0];
                     flag_z       <= (prod_q == '0);
                     flag_c       <= 1'b0;
                     flag_n       <= prod_q[2*DATA_W-1];
                     pc           <= pc + PC_W'(1);
                  end
                  OP_SUB, OP_RRS, OP_NAND, OP_OR: begin
                     regs[rd_q] <= res_q;
                     flag_z     <= (res_q == '0);
                     flag_c     <= c_q;
                     flag_n     <= res_q[DATA_W-1];
                     pc         <= pc + PC_W'(1);
                  end
                  OP_BZ:   pc <= flag_z ? pc + imm_sext : pc + PC_W'(1);
                  default: pc <= pc + PC_W'(1);
               endcase
            end
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_core.sv
// Self-checking bench for mc_core: directed scenarios plus randomized
// instructions compared against an arithmetic reference model.
module tb_mc_core;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] ir = '0;
   logic        ir_valid = 1'b0;
   logic        ir_ready;
   logic [31:0] pc;
   logic        flag_z, flag_c, flag_n;
   logic        done, illegal, busy;
   logic [4:0]  dbg_addr = '0;
   logic [31:0] dbg_data;

   int unsigned checks = 0;
   int unsigned errors = 0;

   logic [31:0] m_regs [32];
   logic [31:0] m_pc;
   logic        m_z, m_c, m_n;

   mc_core #(.DATA_W(32), .REG_CNT(32), .PC_W(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .ir       (ir),
      .ir_valid (ir_valid),
      .ir_ready (ir_ready),
      .pc       (pc),
      .flag_z   (flag_z),
      .flag_c   (flag_c),
      .flag_n   (flag_n),
      .done     (done),
      .illegal  (illegal),
      .busy     (busy),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic peek(input logic [4:0] a, output logic [31:0] v);
      dbg_addr = a;
      #1;
      v = dbg_data;
   endtask

   function automatic logic [12:0] lo_rb(input logic [4:0] rb);
      logic [7:0] junk;
      junk = 8'($urandom);
      return {rb, junk};
   endfunction

   function automatic logic [12:0] lo_imm(input logic [8:0] imm);
      logic [3:0] junk;
      junk = 4'($urandom);
      return {junk, imm};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'(i);
      m_pc = '0;
      m_z = 1'b0;
      m_c = 1'b0;
      m_n = 1'b0;
   endtask

   task automatic model_exec(input logic [7:0] op, input logic [4:0] rd, input logic [4:0] ra,
                             input logic [12:0] low, output bit ill);
      logic [31:0] a, b, r;
      logic [63:0] p;
      logic [8:0]  imm;
      logic [4:0]  rd1;
      int          sh;
      a   = m_regs[ra];
      b   = m_regs[low[12:8]];
      imm = low[8:0];
      rd1 = rd + 5'd1;
      ill = 1'b0;
      case (op)
         8'h0A: begin
            r = a - b;
            m_c = (a < b); m_z = (r == 0); m_n = r[31];
            m_regs[rd] = r; m_pc = m_pc + 1;
         end
         8'h1A: begin
            p = {32'b0, a} * {32'b0, b};
            m_regs[rd] = p[63:32]; m_regs[rd1] = p[31:0];
            m_c = 1'b0; m_z = (p == 0); m_n = p[63];
            m_pc = m_pc + 1;
         end
         8'h21: begin
            sh = int'(b % 32);
            r = $signed(a) >>> sh;
            m_c = (sh == 0) ? 1'b0 : a[sh-1];
            m_z = (r == 0); m_n = r[31];
            m_regs[rd] = r; m_pc = m_pc + 1;
         end
         8'h22, 8'h23: begin
            r = (op == 8'h22) ? ~(a & b) : (a | b);
            m_c = 1'b0; m_z = (r == 0); m_n = r[31];
            m_regs[rd] = r; m_pc = m_pc + 1;
         end
         8'h14: m_pc = m_z ? m_pc + {{23{imm[8]}}, imm} : m_pc + 1;
         default: begin
            ill = 1'b1;
            m_pc = m_pc + 1;
         end
      endcase
   endtask

   task automatic do_reset();
      logic [31:0] v;
      @(negedge clk);
      ir_valid = 1'b0;
      reset = 1'b1;
      #1;
      check_eq("rst_ready_low", ir_ready, 1'b0);
      check_eq("rst_busy", busy, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      #1;
      check_eq("rst_pc", pc, 32'd0);
      check_eq("rst_flags", {flag_z, flag_c, flag_n}, 3'b000);
      check_eq("rst_pulses", {done, illegal, busy}, 3'b000);
      check_eq("rst_ready", ir_ready, 1'b1);
      peek(5'd5, v);  check_eq("rst_r5", v, 32'd5);
      peek(5'd31, v); check_eq("rst_r31", v, 32'd31);
   endtask

   task automatic run_instr(input logic [7:0] op, input logic [4:0] rd, input logic [4:0] ra,
                            input logic [12:0] low);
      logic [31:0] v;
      logic [4:0]  rnd, rd1;
      bit          ill, bad_rdy, got_done, got_ill;
      int          n;
      @(negedge clk);
      ir = {op, 1'($urandom), rd, ra, low};
      ir_valid = 1'b1;
      #1;
      check_eq("accept_ready", ir_ready, 1'b1);
      @(posedge clk);
      n = 0; got_done = 1'b0; got_ill = 1'b0; bad_rdy = 1'b0;
      while (n < 80 && !got_done) begin
         @(negedge clk);
         n++;
         ir = $urandom;
         if (ir_ready || !busy) bad_rdy = 1'b1;
         got_done = done;
         got_ill  = illegal;
      end
      ir_valid = 1'b0;
      check_eq("done_seen", got_done, 1'b1);
      check_eq("latency", n, (op == 8'h1A) ? 34 : 3);
      check_eq("ready_low_busy", bad_rdy, 1'b0);
      model_exec(op, rd, ra, low, ill);
      check_eq("illegal_pulse", got_ill, ill);
      @(negedge clk);
      #1;
      check_eq("pc", pc, m_pc);
      check_eq("flags", {flag_z, flag_c, flag_n}, {m_z, m_c, m_n});
      check_eq("post_idle", {done, illegal, busy, ir_ready}, 4'b0001);
      rd1 = rd + 5'd1;
      rnd = 5'($urandom);
      peek(rd, v);  check_eq("reg_rd", v, m_regs[rd]);
      peek(rd1, v); check_eq("reg_rd1", v, m_regs[rd1]);
      peek(rnd, v); check_eq("reg_any", v, m_regs[rnd]);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      logic [7:0]  ops [6];
      logic [7:0]  op;
      logic [2:0]  fl;
      ops = '{8'h0A, 8'h1A, 8'h21, 8'h22, 8'h23, 8'h14};
      model_reset();

      do_reset();
      run_instr(8'h0A, 5'd1, 5'd2, lo_rb(5'd3));
      peek(5'd1, v); check_eq("sub_r1", v, 32'hFFFF_FFFF);
      check_eq("sub_flags", {flag_z, flag_c, flag_n}, 3'b011);
      check_eq("sub_pc", pc, 32'd1);

      run_instr(8'h1A, 5'd1, 5'd2, lo_rb(5'd3));
      peek(5'd1, v); check_eq("mult_hi", v, 32'd0);
      peek(5'd2, v); check_eq("mult_lo", v, 32'd6);

      run_instr(8'h21, 5'd3, 5'd4, lo_rb(5'd5));
      peek(5'd3, v); check_eq("rrs_zero", v, 32'd0);
      check_eq("rrs_zc", {flag_z, flag_c}, 2'b10);

      // build R4 = 0x80000000 (keeping a 4 in R21) from products of powers of two
      run_instr(8'h23, 5'd21, 5'd4, lo_rb(5'd0));
      run_instr(8'h1A, 5'd10, 5'd16, lo_rb(5'd16));
      run_instr(8'h1A, 5'd12, 5'd11, lo_rb(5'd11));
      run_instr(8'h1A, 5'd14, 5'd11, lo_rb(5'd8));
      run_instr(8'h1A, 5'd17, 5'd15, lo_rb(5'd16));
      run_instr(8'h1A, 5'd3, 5'd13, lo_rb(5'd18));
      peek(5'd4, v); check_eq("r4_msb", v, 32'h8000_0000);
      run_instr(8'h21, 5'd3, 5'd4, lo_rb(5'd21));
      peek(5'd3, v); check_eq("rrs_sign", v, 32'hF800_0000);
      check_eq("rrs_n", flag_n, 1'b1);

      run_instr(8'h1A, 5'd31, 5'd5, lo_rb(5'd6));
      peek(5'd0, v); check_eq("mult_wrap_r0", v, 32'd30);

      do_reset();
      run_instr(8'h0A, 5'd0, 5'd0, lo_rb(5'd0));
      check_eq("sub0_z", flag_z, 1'b1);
      run_instr(8'h14, 5'($urandom), 5'($urandom), lo_imm(9'd7));
      check_eq("bz_fwd", pc, 32'd8);
      run_instr(8'h14, 5'($urandom), 5'($urandom), lo_imm(9'h1FE));
      check_eq("bz_back", pc, 32'd6);
      run_instr(8'h0A, 5'd1, 5'd2, lo_rb(5'd3));
      run_instr(8'h14, 5'($urandom), 5'($urandom), lo_imm(9'd7));
      check_eq("bz_not_taken", pc, 32'd8);

      fl = {flag_z, flag_c, flag_n};
      run_instr(8'hFF, 5'd1, 5'd2, lo_rb(5'd3));
      check_eq("ill_flags_kept", {flag_z, flag_c, flag_n}, fl);
      check_eq("ill_pc", pc, 32'd9);

      // reset during the tenth EXEC cycle of a multiply
      do_reset();
      @(negedge clk);
      ir = {8'h1A, 1'b0, 5'd1, 5'd2, lo_rb(5'd3)};
      ir_valid = 1'b1;
      @(posedge clk);
      repeat (11) @(negedge clk);
      check_eq("mid_mult_busy", busy, 1'b1);
      ir_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      check_eq("async_rst_state", {busy, done, ir_ready}, 3'b000);
      check_eq("async_rst_pc", pc, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      #1;
      peek(5'd1, v); check_eq("drop_r1", v, 32'd1);
      peek(5'd2, v); check_eq("drop_r2", v, 32'd2);
      run_instr(8'h0A, 5'd1, 5'd2, lo_rb(5'd3));

      for (int k = 0; k < 200; k++) begin
         if ($urandom_range(0, 9) == 0) begin
            op = 8'($urandom);
            if (op inside {8'h0A, 8'h1A, 8'h21, 8'h22, 8'h23, 8'h14}) op = 8'hFF;
         end else begin
            op = ops[$urandom_range(0, 5)];
         end
         run_instr(op, 5'($urandom), 5'($urandom), 13'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
